// File: rtl/axi4_frame_reader_pkg.sv
// Shared definitions for the AXI4 frame reader.
// Holds the FSM state encoding, the fixed AXI attribute values driven on the
// AR channel, and small elaboration-time helper functions.
package axi4_frame_pkg;

    // FSM state encoding, also exported on the debug 'state' port
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // AXI attribute constants
    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [3:0] CACHE_WB        = 4'b1111;
    localparam int         RESP_SLVERR_BIT = 1;

    // Bytes moved by one burst
    function automatic int burst_bytes(input int burst_len, input int data_w);
        return burst_len * (data_w / 8);
    endfunction

    // True when v is a positive power of two
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi4_frame_reader_if.sv
// AXI4 read-only bus (AR + R channels) between the frame reader and the
// DDR port.
//   master: driven by the frame reader (ARADDR/ARVALID/ARLEN/ARSIZE/ARBURST/
//           ARCACHE/RREADY out; ARREADY/RDATA/RVALID/RLAST/RRESP in)
//   slave : the memory side, mirror image of master
interface axi4_frame_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [3:0]        ARCACHE;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              RREADY;
    logic              RLAST;
    logic [1:0]        RRESP;

    modport master (
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, RREADY,
        input  ARREADY, RDATA, RVALID, RLAST, RRESP
    );

    modport slave (
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, RREADY,
        output ARREADY, RDATA, RVALID, RLAST, RRESP
    );
endinterface

// File: rtl/axi4_frame_reader_rd_credit.sv
// Outstanding-burst tracker and FIFO credit check for the frame reader.
// Ports:
//   clk, rst          clock, async active-high reset
//   ar_hs             AR handshake this cycle (one burst enters flight)
//   rlast_hs          accepted RLAST beat this cycle (one burst leaves flight)
//   fifo_space        free words in the downstream FIFO
//   outstanding       registered count of bursts in flight
//   outstanding_next  count after this cycle's handshakes
//   issue_ok          another burst fits in both the in-flight limit and the
//                     FIFO space, with space reserved for every burst already
//                     in flight
module axi4_rd_credit #(
    parameter int BURST_LEN       = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_CNT_W      = 11
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ar_hs,
    input  logic                                   rlast_hs,
    input  logic [FIFO_CNT_W-1:0]                  fifo_space,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_next,
    output logic                                   issue_ok
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    // Wide enough for (MAX_OUTSTANDING+1)*BURST_LEN without truncation
    localparam int CW    = FIFO_CNT_W + 4;

    logic [OUT_W-1:0] outstanding_r;
    logic [CW-1:0]    need_s;
    logic [CW-1:0]    space_s;

    // Next in-flight count; simultaneous issue and retire cancel out
    always_comb begin
        outstanding_next = outstanding_r;
        if (ar_hs && !rlast_hs) begin
            outstanding_next = outstanding_r + OUT_W'(1);
        end else if (rlast_hs && !ar_hs && (outstanding_r != OUT_W'(0))) begin
            outstanding_next = outstanding_r - OUT_W'(1);
        end else begin
            outstanding_next = outstanding_r;
        end
    end

    // In-flight burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= OUT_W'(0);
        end else begin
            outstanding_r <= outstanding_next;
        end
    end

    assign need_s      = (CW'(outstanding_r) + CW'(1)) * CW'(BURST_LEN);
    assign space_s     = CW'(fifo_space);
    assign issue_ok    = (outstanding_r < OUT_W'(MAX_OUTSTANDING)) && (space_s >= need_s);
    assign outstanding = outstanding_r;

endmodule

// File: rtl/axi4_frame_reader.sv
// AXI4 read master streaming one frame from a multi-buffer DDR frame store
// into a downstream pixel FIFO, with several bursts in flight.
// Ports:
//   clk_100Mhz, rst   clock, async active-high reset
//   frame_start       one-cycle pulse starting a new frame
//   buf_select        frame buffer to read, sampled on frame_start
//   fifo_space        free words in the downstream FIFO
//   fifo_din/wr_en    FIFO write side (data is RDATA passed straight through)
//   axi               AXI4 AR/R master port
//   frame_done        one-cycle pulse after the last beat of the frame
//   rresp_err         sticky error flag, cleared on frame_start
//   state, ADDR_OFFSET debug: FSM state and offset of the next burst
module axi4_frame_reader
    import axi4_frame_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH  = 32,
    parameter int          AXI_DATA_WIDTH  = 64,
    parameter int          BURST_LEN       = 64,
    parameter int          FRAME_BYTES     = 153600,
    parameter int          NUM_BUFS        = 2,
    parameter logic [31:0] BUF_BASE        = 32'h0100_0000,
    parameter logic [31:0] BUF_STRIDE      = 32'h0010_0000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          FIFO_CNT_W      = 11
) (
    input  logic                                          clk_100Mhz,
    input  logic                                          rst,
    input  logic                                          frame_start,
    input  logic [((NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1)-1:0] buf_select,
    input  logic [FIFO_CNT_W-1:0]                         fifo_space,
    output logic [AXI_DATA_WIDTH-1:0]                     fifo_din,
    output logic                                          fifo_wr_en,
    axi4_frame_reader_if.master                           axi,
    output logic                                          frame_done,
    output logic                                          rresp_err,
    output logic [1:0]                                    state,
    output logic [AXI_ADDR_WIDTH-1:0]                     ADDR_OFFSET
);
    localparam int SEL_W       = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int BURST_BYTES = burst_bytes(BURST_LEN, AXI_DATA_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_STEP = AXI_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] FRAME_END  = AXI_ADDR_WIDTH'(FRAME_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE0      = AXI_ADDR_WIDTH'(BUF_BASE);

    // Reject parameter sets that could break the 4 KB rule or the frame tiling
    if ((BURST_LEN < 1) || (BURST_LEN > 256) ||
        !is_pow2(BURST_BYTES) || (BURST_BYTES > 4096) ||
        (FRAME_BYTES <= 0) || ((FRAME_BYTES % BURST_BYTES) != 0) ||
        (NUM_BUFS < 1) || (NUM_BUFS > 8) ||
        (MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 8) ||
        ((BUF_BASE % 4096) != 0) || ((BUF_STRIDE % 4096) != 0)) begin : g_param_check
        $error("axi4_frame_reader: illegal parameter combination");
    end

    logic [1:0]                state_r;
    logic                      arvalid_r;
    logic [AXI_ADDR_WIDTH-1:0] araddr_r;
    logic [AXI_ADDR_WIDTH-1:0] off_r;
    logic [SEL_W-1:0]          buf_r;
    logic                      frame_done_r;
    logic                      rresp_err_r;

    logic                      rready_s;
    logic                      ar_hs_s;
    logic                      r_hs_s;
    logic                      rlast_hs_s;
    logic                      issue_ok_s;
    logic                      issue_s;
    logic                      busy_s;
    logic [SEL_W-1:0]          sel_s;
    logic [AXI_ADDR_WIDTH-1:0] base_s;
    logic [OUT_W-1:0]          outstanding_s;
    logic [OUT_W-1:0]          outstanding_next_s;

    axi4_rd_credit #(
        .BURST_LEN       (BURST_LEN),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .FIFO_CNT_W      (FIFO_CNT_W)
    ) u_credit (
        .clk              (clk_100Mhz),
        .rst              (rst),
        .ar_hs            (ar_hs_s),
        .rlast_hs         (rlast_hs_s),
        .fifo_space       (fifo_space),
        .outstanding      (outstanding_s),
        .outstanding_next (outstanding_next_s),
        .issue_ok         (issue_ok_s)
    );

    assign rready_s   = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign ar_hs_s    = arvalid_r && axi.ARREADY;
    assign r_hs_s     = axi.RVALID && rready_s;
    assign rlast_hs_s = r_hs_s && axi.RLAST;

    // Out-of-range selections fall back to buffer 0
    assign sel_s  = (int'(buf_select) < NUM_BUFS) ? buf_select : {SEL_W{1'b0}};
    assign base_s = BASE0 + (AXI_ADDR_WIDTH'(buf_r) * AXI_ADDR_WIDTH'(BUF_STRIDE));

    // No new request on a frame_start cycle: it would carry the old base
    assign issue_s = (state_r == ST_RUN) && !arvalid_r && !frame_start &&
                     (off_r < FRAME_END) && issue_ok_s;

    // A request still waiting for ARREADY counts as in flight
    assign busy_s = (outstanding_next_s != OUT_W'(0)) || (arvalid_r && !axi.ARREADY);

    // AR channel, frame FSM and status flags
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            arvalid_r    <= 1'b0;
            araddr_r     <= BASE0;
            off_r        <= {AXI_ADDR_WIDTH{1'b0}};
            buf_r        <= {SEL_W{1'b0}};
            frame_done_r <= 1'b0;
            rresp_err_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;

            // ARVALID is held until accepted, whatever the FSM does
            if (arvalid_r) begin
                if (axi.ARREADY) begin
                    arvalid_r <= 1'b0;
                    off_r     <= off_r + BURST_STEP;
                end else begin
                    arvalid_r <= 1'b1;
                end
            end else if (issue_s) begin
                arvalid_r <= 1'b1;
                araddr_r  <= base_s + off_r;
            end else begin
                arvalid_r <= 1'b0;
            end

            if (r_hs_s && axi.RRESP[RESP_SLVERR_BIT]) begin
                rresp_err_r <= 1'b1;
            end else begin
                rresp_err_r <= rresp_err_r;
            end

            if (frame_start) begin
                buf_r       <= sel_s;
                rresp_err_r <= 1'b0;
            end else begin
                buf_r       <= buf_r;
            end

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (frame_start) begin
                        off_r   <= {AXI_ADDR_WIDTH{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (frame_start) begin
                        if (busy_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            off_r   <= {AXI_ADDR_WIDTH{1'b0}};
                            state_r <= ST_RUN;
                        end
                    end else if (rlast_hs_s && (outstanding_next_s == OUT_W'(0)) &&
                                 (off_r == FRAME_END)) begin
                        frame_done_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding_s == OUT_W'(0)) && !arvalid_r) begin
                        off_r   <= {AXI_ADDR_WIDTH{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi.ARADDR  = araddr_r;
    assign axi.ARVALID = arvalid_r;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARCACHE = CACHE_WB;
    assign axi.RREADY  = rready_s;

    // Beats drained after a frame restart are accepted but never written
    assign fifo_wr_en  = axi.RVALID && rready_s && (state_r == ST_RUN);
    assign fifo_din    = axi.RDATA;
    assign frame_done  = frame_done_r;
    assign rresp_err   = rresp_err_r;
    assign state       = state_r;
    assign ADDR_OFFSET = off_r;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Directed bench for axi4_frame_reader: a cycle-stepped AXI slave model with
// fixed read latency, an expected-ARADDR scoreboard queue and per-beat data
// checks, plus directed checks for credit limiting, ARREADY stalls, drain on
// restart, RRESP errors and asynchronous reset.
module tb_axi4_frame_reader;

    typedef struct {
        logic [31:0] addr;
        int          t;
        int          id;
    } burst_t;

    logic        clk_100Mhz;
    logic        rst;
    logic        frame_start;
    logic [0:0]  buf_select;
    logic [10:0] fifo_space;
    logic [63:0] fifo_din;
    logic        fifo_wr_en;
    logic        frame_done;
    logic        rresp_err;
    logic [1:0]  state;
    logic [31:0] ADDR_OFFSET;

    axi4_frame_reader_if #(.ADDR_W(32), .DATA_W(64)) axi ();

    axi4_frame_reader dut (
        .clk_100Mhz  (clk_100Mhz),
        .rst         (rst),
        .frame_start (frame_start),
        .buf_select  (buf_select),
        .fifo_space  (fifo_space),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .axi         (axi),
        .frame_done  (frame_done),
        .rresp_err   (rresp_err),
        .state       (state),
        .ADDR_OFFSET (ADDR_OFFSET)
    );

    initial clk_100Mhz = 1'b0;
    always #5 clk_100Mhz = ~clk_100Mhz;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc = 0;
    int          lat = 10;
    int          ar_ready_en = 1;
    int          err_burst = -1;
    int          burst_id = 0;
    int          beat = 0;
    int          inflight = 0;
    int          max_inflight = 0;
    int          ar_cnt = 0;
    int          wr_cnt = 0;
    int          drain_beats = 0;
    int          done_cnt = 0;
    int          done_at_wr = -1;
    logic [31:0] last_ar = 32'h0;
    logic [31:0] exp_ar[$];
    burst_t      r_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic [31:0] base);
        exp_ar.delete();
        for (int i = 0; i < 300; i++) exp_ar.push_back(base + 32'(i * 512));
    endtask

    // One clock of the slave model: drive at negedge, predict handshakes at the
    // following posedge and check what the DUT presents.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk_100Mhz);
        cyc++;
        if (rst) begin
            r_q.delete();
            beat = 0;
            inflight = 0;
            axi.ARREADY = 1'b0;
            axi.RVALID = 1'b0;
            axi.RLAST = 1'b0;
            axi.RRESP = 2'b00;
        end else begin
            axi.ARREADY = (ar_ready_en != 0);
            if (r_q.size() > 0 && cyc >= r_q[0].t) begin
                axi.RVALID = 1'b1;
                axi.RDATA  = {r_q[0].addr, 32'(beat)};
                axi.RLAST  = (beat == 63);
                axi.RRESP  = (r_q[0].id == err_burst && beat == 5) ? 2'b10 : 2'b00;
            end else begin
                axi.RVALID = 1'b0;
                axi.RLAST  = 1'b0;
                axi.RRESP  = 2'b00;
            end
        end
        #1;
        if (!rst) begin
            if (axi.ARVALID && axi.ARREADY) begin
                ar_cnt++;
                last_ar = axi.ARADDR;
                chk("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
                if (exp_ar.size() > 0) begin
                    e = exp_ar.pop_front();
                    chk("araddr", 64'(axi.ARADDR), 64'(e));
                end
                r_q.push_back('{axi.ARADDR, cyc + lat, burst_id});
                burst_id++;
                inflight++;
                if (inflight > max_inflight) max_inflight = inflight;
            end
            if (fifo_wr_en) begin
                wr_cnt++;
                if (r_q.size() > 0) chk("fifo_din", fifo_din, {r_q[0].addr, 32'(beat)});
            end
            if (axi.RVALID && axi.RREADY) begin
                if (!fifo_wr_en) drain_beats++;
                if (axi.RLAST) begin
                    void'(r_q.pop_front());
                    beat = 0;
                    inflight--;
                end else begin
                    beat++;
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_at_wr = wr_cnt;
            end
        end
    endtask

    initial begin
        int          n0;
        int          n_wr;
        logic [31:0] held;
        bit          ok;

        rst = 1'b1;
        frame_start = 1'b0;
        buf_select = 1'b0;
        fifo_space = 11'd1024;
        axi.ARREADY = 1'b0;
        axi.RVALID = 1'b0;
        axi.RDATA = 64'h0;
        axi.RLAST = 1'b0;
        axi.RRESP = 2'b00;

        // Reset values
        tick(); tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_arvalid", 64'(axi.ARVALID), 64'd0);
        chk("rst_rready", 64'(axi.RREADY), 64'd0);
        chk("rst_araddr", 64'(axi.ARADDR), 64'h0100_0000);
        chk("rst_offset", 64'(ADDR_OFFSET), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(rresp_err), 64'd0);
        chk("arlen", 64'(axi.ARLEN), 64'd63);
        chk("arsize", 64'(axi.ARSIZE), 64'd3);
        chk("arburst", 64'(axi.ARBURST), 64'd1);
        chk("arcache", 64'(axi.ARCACHE), 64'hF);
        rst = 1'b0;
        tick();

        // Full frame from buffer 1, SLVERR injected on beat 5 of burst 2
        load_frame(32'h0110_0000);
        burst_id = 0; err_burst = 1; wr_cnt = 0; done_cnt = 0;
        buf_select = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f1_state_run", 64'(state), 64'd1);
        repeat (5) tick();
        chk("f1_err_clear", 64'(rresp_err), 64'd0);
        for (int i = 0; i < 30000; i++) begin
            if (done_cnt > 0) break;
            tick();
        end
        chk("f1_done_timeout", 64'(done_cnt > 0), 64'd1);
        chk("f1_done_after_last", 64'(done_at_wr), 64'd19200);
        repeat (3) tick();
        chk("f1_done_once", 64'(done_cnt), 64'd1);
        chk("f1_state_done", 64'(state), 64'd3);
        chk("f1_rresp_err", 64'(rresp_err), 64'd1);
        chk("f1_all_ar", 64'(exp_ar.size()), 64'd0);
        chk("f1_writes", 64'(wr_cnt), 64'd19200);
        chk("f1_rready_done", 64'(axi.RREADY), 64'd0);
        chk("f1_arvalid_done", 64'(axi.ARVALID), 64'd0);

        // Buffer 0 with space for only two bursts
        load_frame(32'h0100_0000);
        burst_id = 0; err_burst = -1; max_inflight = 0;
        fifo_space = 11'd130;
        buf_select = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f2_err_cleared", 64'(rresp_err), 64'd0);
        chk("f2_state_run", 64'(state), 64'd1);
        repeat (600) tick();
        chk("f2_max_inflight", 64'(max_inflight), 64'd2);

        // ARREADY stalled for 20 cycles
        ar_ready_en = 0;
        tick();
        for (int i = 0; i < 300; i++) begin
            if (axi.ARVALID) break;
            tick();
        end
        chk("stall_arvalid_seen", 64'(axi.ARVALID), 64'd1);
        held = axi.ARADDR;
        n0 = ar_cnt;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (!axi.ARVALID || axi.ARADDR !== held) ok = 1'b0;
        end
        chk("stall_stable", 64'(ok), 64'd1);
        chk("stall_no_hs", 64'(ar_cnt), 64'(n0));
        ar_ready_en = 1;
        tick();
        chk("stall_first_ready_hs", 64'(ar_cnt), 64'(n0 + 1));
        chk("stall_addr", 64'(last_ar), 64'(held));
        tick();
        chk("stall_arvalid_drop", 64'(axi.ARVALID), 64'd0);

        // Too little space for even one burst
        fifo_space = 11'd63;
        for (int i = 0; i < 1000; i++) begin
            if (inflight == 0 && !axi.ARVALID) break;
            tick();
        end
        chk("low_space_idle", 64'(inflight == 0 && !axi.ARVALID), 64'd1);
        n0 = ar_cnt;
        ok = 1'b0;
        repeat (100) begin
            tick();
            if (axi.ARVALID) ok = 1'b1;
        end
        chk("low_space_no_arvalid", 64'(ok), 64'd0);
        chk("low_space_no_hs", 64'(ar_cnt), 64'(n0));
        chk("low_space_state", 64'(state), 64'd1);

        // Restart with three bursts in flight
        lat = 40;
        fifo_space = 11'd192;
        for (int i = 0; i < 100; i++) begin
            if (inflight == 3) break;
            tick();
        end
        chk("drain_three_inflight", 64'(inflight), 64'd3);
        tick();
        chk("drain_no_fourth", 64'(axi.ARVALID), 64'd0);
        load_frame(32'h0100_0000);
        drain_beats = 0;
        n_wr = wr_cnt;
        n0 = ar_cnt;
        buf_select = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("drain_state", 64'(state), 64'd2);
        for (int i = 0; i < 1000; i++) begin
            if (state == 2'd1) break;
            tick();
        end
        chk("drain_exit_run", 64'(state), 64'd1);
        chk("drain_beats", 64'(drain_beats), 64'd192);
        chk("drain_no_writes", 64'(wr_cnt), 64'(n_wr));
        chk("drain_no_ar", 64'(ar_cnt), 64'(n0));
        chk("drain_offset0", 64'(ADDR_OFFSET), 64'd0);
        for (int i = 0; i < 50; i++) begin
            if (ar_cnt != n0) break;
            tick();
        end
        chk("resume_ar", 64'(ar_cnt), 64'(n0 + 1));
        chk("resume_addr", 64'(last_ar), 64'h0100_0000);
        tick();
        chk("resume_offset", 64'(ADDR_OFFSET), 64'd512);

        // Asynchronous reset in the middle of a burst
        lat = 5;
        fifo_space = 11'd1024;
        for (int i = 0; i < 300; i++) begin
            if (axi.RVALID && axi.RREADY) break;
            tick();
        end
        chk("mid_burst_wr_en", 64'(fifo_wr_en), 64'd1);
        n0 = done_cnt;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_arvalid", 64'(axi.ARVALID), 64'd0);
        chk("async_rst_rready", 64'(axi.RREADY), 64'd0);
        chk("async_rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("async_rst_state", 64'(state), 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("async_rst_no_done", 64'(done_cnt), 64'(n0));
        chk("async_rst_idle", 64'(state), 64'd0);
        chk("async_rst_offset", 64'(ADDR_OFFSET), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axi4_frame_reader.md
Name: axi4_frame_reader

Overview:
- Parametrised AXI4 read master that streams one frame from an N-way DDR frame buffer into a write-side pixel FIFO. It is the next generation of the single-outstanding frame reader.
- New capabilities:
  - keeps up to MAX_OUTSTANDING bursts in flight, with FIFO-space credit reservation;
  - selects among NUM_BUFS buffers, latched at frame start;
  - stops at end of frame;
  - drains in-flight bursts cleanly when a new frame starts (no AXI protocol violation);
  - reports RRESP errors.
- Sits in the clk_100Mhz domain between the PS DDR HP port and the async pixel FIFO. The FIFO itself stays outside this block.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, RDATA and FIFO word width
BURST_LEN, 64, beats per burst (1..256); BURST_LEN*AXI_DATA_WIDTH/8 must be a power of two and <= 4096
FRAME_BYTES, 153600, bytes per frame (320x240x16bit); must be a multiple of the burst byte count
NUM_BUFS, 2, number of frame buffers (1..8)
BUF_BASE, 32'h0100_0000, address of buffer 0; must be 4 KB aligned
BUF_STRIDE, 32'h0010_0000, address step between buffers; must be 4 KB aligned
MAX_OUTSTANDING, 4, maximum in-flight bursts (1..8)
FIFO_CNT_W, 11, width of fifo_space

Ports:
clk_100Mhz  in  1  sole clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse (synchronised vsync): begin a new frame
buf_select  in  $clog2(NUM_BUFS) (min 1)  buffer to read; sampled only on frame_start
fifo_space  in  FIFO_CNT_W  free words in the downstream FIFO (full depth minus wr_data_count)
fifo_din  out  AXI_DATA_WIDTH  equals RDATA
fifo_wr_en  out  1  write strobe to the FIFO
ARADDR  out  AXI_ADDR_WIDTH  burst address
ARVALID  out  1  address valid
ARREADY  in  1  address ready
ARLEN  out  8  constant BURST_LEN-1
ARSIZE  out  3  constant $clog2(AXI_DATA_WIDTH/8)
ARBURST  out  2  constant 2'b01 (INCR)
ARCACHE  out  4  constant 4'b1111
RDATA  in  AXI_DATA_WIDTH  read data
RVALID  in  1  read valid
RREADY  out  1  read ready
RLAST  in  1  last beat of a burst
RRESP  in  2  read response
frame_done  out  1  one-cycle pulse when the final beat of the frame is written
rresp_err  out  1  sticky; cleared on frame_start
state  out  2  debug: current FSM state
ADDR_OFFSET  out  AXI_ADDR_WIDTH  debug: byte offset of the next burst to issue

Behaviour:
- Reset values (asynchronous): state=IDLE, ARVALID=0, RREADY=0, ARADDR=BUF_BASE, ADDR_OFFSET=0, outstanding=0, fifo_wr_en=0, frame_done=0, rresp_err=0, latched buffer=0.
- FSM states and transitions:
  - IDLE(0), RUN(1), DRAIN(2), DONE(3).
  - frame_start in IDLE or DONE: latch base = BUF_BASE + buf_select*BUF_STRIDE; ADDR_OFFSET=0; rresp_err=0; go to RUN.
  - frame_start in RUN with outstanding>0 (counted after any same-cycle AR handshake): latch the new buffer, go to DRAIN.
  - frame_start in RUN with outstanding==0: restart RUN immediately.
  - frame_start in DRAIN: re-latch buffer, stay in DRAIN.
  - DRAIN exits to RUN (ADDR_OFFSET=0) in the cycle after outstanding reaches 0.
- AR issue, RUN only:
  - Assert ARVALID when all of these hold: ARVALID==0, ADDR_OFFSET<FRAME_BYTES, outstanding<MAX_OUTSTANDING, and fifo_space >= (outstanding+1)*BURST_LEN (space is reserved for every in-flight burst).
  - ARADDR = base + ADDR_OFFSET, registered together with ARVALID.
  - ARADDR and ARVALID stay stable until ARREADY. ARVALID is never withdrawn, even on frame_start; a pending request completes and is then drained.
  - On handshake: ARVALID=0, ADDR_OFFSET += BURST_LEN*AXI_DATA_WIDTH/8, outstanding+1.
  - Minimum gap between requests is 1 idle cycle.
- R channel:
  - RREADY=1 whenever state is RUN or DRAIN. The credit reservation guarantees the FIFO never overflows.
  - fifo_wr_en = RVALID && RREADY && state==RUN, combinational; fifo_din = RDATA.
  - RVALID && RREADY && RLAST: outstanding-1.
  - AR handshake and RLAST in the same cycle: outstanding unchanged.
  - RRESP[1]==1 on any accepted beat sets rresp_err. The data is still written.
- End of frame:
  - In RUN, when ADDR_OFFSET==FRAME_BYTES and a RLAST beat drops outstanding to 0: frame_done=1 for one cycle, then go to DONE.
  - DONE: RREADY=0, ARVALID=0.
- Widths:
  - outstanding is $clog2(MAX_OUTSTANDING+1) bits.
  - The credit product is computed at FIFO_CNT_W+4 bits; no truncation.
- 4 KB crossing is impossible by the parameter constraints. Elaboration fails ($error) if a constraint is violated.
- Mid-operation reset is asynchronous and abandons in-flight bursts. The system resets the interconnect on the same rst.

Decomposition:
- Package axi4_frame_pkg: state encoding (IDLE/RUN/DRAIN/DONE), AXI constants (BURST_INCR, CACHE_WB=4'b1111, RESP_SLVERR bit), and a function computing burst bytes.
- One natural sub-module: axi4_rd_credit, which holds the outstanding counter, the credit compare, and the issue-enable output.

Test Plan:
- Reset, frame_start with buf_select=1, fifo_space=1024, ARREADY=1, slave latency 10 -> 300 bursts; ARADDR 0x0110_0000, 0x0110_0200, …, last 0x0112_5600; frame_done once after the 19200th beat; state returns to 3.
- fifo_space held at 130, MAX_OUTSTANDING=4 -> never more than 2 bursts in flight; fifo_space=63 -> no ARVALID.
- ARREADY held low for 20 cycles -> ARVALID stays 1 with ARADDR constant; burst issues on the first ARREADY=1 cycle.
- frame_start with 3 bursts in flight, buf_select=0 -> no further ARs; 192 beats accepted with fifo_wr_en=0; then RUN resumes at ARADDR 0x0100_0000.
- RRESP=2'b10 on beat 5 of burst 2 -> rresp_err=1 until the next frame_start; all 64 beats still written.
- rst asserted mid-burst, asynchronously between clock edges -> ARVALID, RREADY, fifo_wr_en go to 0 immediately; no frame_done.
